// File: rtl/morse_letter_decoder.sv
// ----------------------------------------------------------------------------
// morse_letter_decoder
//
// Decodes a hand-keyed Morse letter (A..H) from a raw key input. Presses are
// timed and classified as glitch / dot / dash. Up to four symbols are collected.
// A long enough release closes the letter, and the letter is then looked up.
//
// Parameters
//   MIN_PRESS   presses shorter than this many cycles are ignored as glitches
//   DASH_MIN    presses at least this many cycles long are dashes, else dots
//   LETTER_GAP  release length in cycles that completes the current letter
//
// Ports
//   clk           system clock
//   rst           asynchronous active-high reset
//   key_in        raw Morse key, 1 = pressed, asynchronous to clk
//   letter        last decoded letter, 0=A .. 7=H
//   letter_valid  one-cycle pulse, letter updated in the same cycle
//   letter_error  one-cycle pulse, unknown sequence or more than 4 symbols
//   busy          high whenever the FSM is not idle
//   sym_count     symbols captured so far for the current letter (0..4)
// ----------------------------------------------------------------------------
module morse_letter_decoder #(
    parameter logic [26:0] MIN_PRESS  = 27'd2_500_000,
    parameter logic [26:0] DASH_MIN   = 27'd50_000_000,
    parameter logic [26:0] LETTER_GAP = 27'd75_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       letter_error,
    output logic       busy,
    output logic [2:0] sym_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRESS = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic        key_meta;
    logic        key_s;
    logic [1:0]  state;
    logic [1:0]  state_n;
    logic [26:0] cnt;
    logic [3:0]  symbols;
    logic        overflow;

    logic        append;
    logic        sym_bit;
    logic        complete;
    logic        lookup_hit;
    logic [2:0]  lookup_code;

    // Symbols are right-aligned: the first symbol keyed sits at the MSB of a
    // sym_count-wide pattern. Bits above sym_count are always zero because
    // the register is cleared at every letter completion.
    function automatic logic [3:0] lookup(input logic [2:0] n, input logic [3:0] s);
        case ({n, s})
            {3'd2, 4'b0001}: lookup = {1'b1, 3'd0};  // A .-
            {3'd4, 4'b1000}: lookup = {1'b1, 3'd1};  // B -...
            {3'd4, 4'b1010}: lookup = {1'b1, 3'd2};  // C -.-.
            {3'd3, 4'b0100}: lookup = {1'b1, 3'd3};  // D -..
            {3'd1, 4'b0000}: lookup = {1'b1, 3'd4};  // E .
            {3'd4, 4'b0010}: lookup = {1'b1, 3'd5};  // F ..-.
            {3'd3, 4'b0110}: lookup = {1'b1, 3'd6};  // G --.
            {3'd4, 4'b0000}: lookup = {1'b1, 3'd7};  // H ....
            default:         lookup = {1'b0, 3'd0};
        endcase
    endfunction

    assign {lookup_hit, lookup_code} = lookup(sym_count, symbols);

    // NOTE: every signal assigned in this block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_n  = state;
        append   = 1'b0;
        sym_bit  = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                if (key_s) state_n = PRESS;
            end
            PRESS: begin
                if (!key_s) begin
                    if (cnt < MIN_PRESS) begin
                        // Glitch: drop it, but keep waiting out the gap if
                        // a letter is already in progress.
                        state_n = (sym_count == 3'd0) ? IDLE : GAP;
                    end else begin
                        append  = 1'b1;
                        sym_bit = (cnt >= DASH_MIN);
                        state_n = GAP;
                    end
                end
            end
            GAP: begin
                // Completion is tested first so a key edge landing on the
                // final gap cycle still closes the letter; the new press is
                // then picked up from IDLE on the next cycle.
                if (cnt == LETTER_GAP - 27'd1) begin
                    complete = 1'b1;
                    state_n  = IDLE;
                end else if (key_s) begin
                    state_n = PRESS;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    // NOTE: every register, including the symbol shift register, is reset so
    // a reset mid-letter leaves no partial symbols behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta     <= 1'b0;
            key_s        <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            symbols      <= '0;
            overflow     <= 1'b0;
            letter       <= '0;
            letter_valid <= 1'b0;
            letter_error <= 1'b0;
            busy         <= 1'b0;
            sym_count    <= '0;
        end else begin
            key_meta <= key_in;
            key_s    <= key_meta;
            state    <= state_n;
            busy     <= (state_n != IDLE);

            // Every state entry is a state change, so clearing on change
            // restarts the duration count on entry.
            if (state_n != state)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + 27'd1;

            letter_valid <= 1'b0;
            letter_error <= 1'b0;

            if (complete) begin
                symbols   <= '0;
                sym_count <= '0;
                overflow  <= 1'b0;
                if (lookup_hit && !overflow) begin
                    letter_valid <= 1'b1;
                    letter       <= lookup_code;
                end else begin
                    letter_error <= 1'b1;
                end
            end else if (append) begin
                if (sym_count == 3'd4) begin
                    overflow <= 1'b1;
                end else begin
                    symbols   <= {symbols[2:0], sym_bit};
                    sym_count <= sym_count + 3'd1;
                end
            end
        end
    end

endmodule
